rv_iopmp_cfg_loader: RTL and testbench

- Register-interface initiator that programs the IOPMP register map at boot or on request, with no software involvement.
- Walks an external programming ROM of {addr, data, mask} records and issues one register write per record.
- Optionally reads each register back and checks the masked value, retrying mismatches.
- Drives the same reg request/response channel that the config abstractor feeds the regmap wrapper with; an upstream reg mux selects between the two.

---
 rtl/rv_iopmp_cfg_loader.sv | 177 +++++++++++++++++
 tb/tb_rv_iopmp_cfg_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_cfg_loader.sv
// rtl/rv_iopmp_cfg_loader.sv - boot-time IOPMP register programmer
// Walks a {addr, data, mask} ROM, writes each register and optionally verifies it.
module rv_iopmp_cfg_loader #(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_RECORDS    = 16,
  parameter int VERIFY_EN      = 1,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [$clog2(NUM_RECORDS):0]      num_records_i,
  output logic                              rom_req_o,
  output logic [$clog2(NUM_RECORDS)-1:0]    rom_idx_o,
  input  logic [REG_ADDR_WIDTH-1:0]         rom_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]         rom_data_i,
  input  logic [REG_DATA_WIDTH-1:0]         rom_mask_i,
  output logic                              reg_valid_o,
  output logic                              reg_write_o,
  output logic [REG_ADDR_WIDTH-1:0]         reg_addr_o,
  output logic [REG_DATA_WIDTH-1:0]         reg_wdata_o,
  output logic [REG_DATA_WIDTH/8-1:0]       reg_wstrb_o,
  input  logic                              reg_ready_i,
  input  logic [REG_DATA_WIDTH-1:0]         reg_rdata_i,
  input  logic                              reg_error_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              error_o,
  output logic [1:0]                        err_code_o,
  output logic [$clog2(NUM_RECORDS)-1:0]    err_idx_o,
  output logic [$clog2(NUM_RECORDS):0]      writes_o
);

  localparam int CW = $clog2(NUM_RECORDS);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CW:0]   NREC    = (CW+1)'(NUM_RECORDS);
  localparam logic [CW:0]   CNT_ONE = (CW+1)'(1);
  localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RTR_ONE = RW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]                state;
  logic [CW:0]               idx;
  logic [CW:0]               num_lat;
  logic [RW-1:0]             retry;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [REG_DATA_WIDTH-1:0] data_q;
  logic [REG_DATA_WIDTH-1:0] mask_q;
  logic [REG_DATA_WIDTH-1:0] rdata_q;
  logic                      at_bound;
  logic                      verify_ok;

  // idx only ever reaches the bound, never past it, so it cannot wrap
  assign at_bound  = (idx == num_lat) || (idx == NREC);
  assign verify_ok = ((rdata_q ^ data_q) & mask_q) == '0;

  assign rom_req_o   = (state == S_FETCH) && !at_bound;
  assign rom_idx_o   = idx[CW-1:0];
  assign reg_valid_o = (state == S_WRITE) || (state == S_READ);
  assign reg_write_o = (state == S_WRITE);
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = data_q;
  assign reg_wstrb_o = '1;
  assign busy_o      = (state == S_FETCH) || (state == S_LATCH) || (state == S_WRITE) ||
                       (state == S_READ)  || (state == S_CHECK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      idx        <= '0;
      num_lat    <= '0;
      retry      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= 2'b00;
      err_idx_o  <= '0;
      writes_o   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state      <= S_FETCH;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_code_o <= 2'b00;
            err_idx_o  <= '0;
            writes_o   <= '0;
            idx        <= '0;
            retry      <= '0;
            num_lat    <= num_records_i;
          end
        end
        S_FETCH: begin
          if (at_bound) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          addr_q <= rom_addr_i;
          data_q <= rom_data_i;
          mask_q <= rom_mask_i;
          // an all-ones address marks the end of the table
          if (&rom_addr_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (reg_ready_i) begin
            if (reg_error_i) begin
              state      <= S_ERROR;
              error_o    <= 1'b1;
              err_code_o <= 2'b01;
              err_idx_o  <= idx[CW-1:0];
            end else begin
              if (writes_o != '1) writes_o <= writes_o + CNT_ONE;
              if (VERIFY_EN != 0) begin
                state <= S_READ;
              end else begin
                idx   <= idx + CNT_ONE;
                state <= S_FETCH;
              end
            end
          end
        end
        S_READ: begin
          if (reg_ready_i) begin
            if (reg_error_i) begin
              state      <= S_ERROR;
              error_o    <= 1'b1;
              err_code_o <= 2'b10;
              err_idx_o  <= idx[CW-1:0];
            end else begin
              rdata_q <= reg_rdata_i;
              state   <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (verify_ok) begin
            retry <= '0;
            idx   <= idx + CNT_ONE;
            state <= S_FETCH;
          end else if (retry < RMAX) begin
            retry <= retry + RTR_ONE;
            state <= S_WRITE;
          end else begin
            state      <= S_ERROR;
            error_o    <= 1'b1;
            err_code_o <= 2'b11;
            err_idx_o  <= idx[CW-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iopmp_cfg_loader.sv
// tb/tb_rv_iopmp_cfg_loader.sv - scoreboard bench for rv_iopmp_cfg_loader
module tb_rv_iopmp_cfg_loader;

  localparam int CW  = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [CW:0] num_records = '0;
  logic        rom_req;
  logic [CW-1:0] rom_idx;
  logic [31:0] rom_addr = '0;
  logic [31:0] rom_data = '0;
  logic [31:0] rom_mask = '0;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic        reg_error = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [CW-1:0] err_idx;
  logic [CW:0] writes;

  rv_iopmp_cfg_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_records_i(num_records),
    .rom_req_o(rom_req), .rom_idx_o(rom_idx), .rom_addr_i(rom_addr),
    .rom_data_i(rom_data), .rom_mask_i(rom_mask),
    .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code),
    .err_idx_o(err_idx), .writes_o(writes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] rom_a [0:15];
  logic [31:0] rom_d [0:15];
  logic [31:0] rom_m [0:15];

  logic        hold_ready = 1'b0;
  logic        force_en = 1'b0;
  logic [31:0] force_addr = '0;
  logic [31:0] force_val = '0;
  logic        werr_en = 1'b0;
  logic [31:0] werr_addr = '0;
  logic [31:0] last_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 32'h0000_0100 + 32'(4 * i);
      rom_d[i] = 32'h1000_0000 + 32'(i);
      rom_m[i] = 32'hFFFF_FFFF;
    end
  endtask

  // start accepted on the posedge between the two negedges; returns in cycle T+1
  task automatic start_run(input int n);
    @(negedge clk);
    start = 1'b1;
    num_records = (CW+1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done || error) break;
      @(negedge clk);
    end
    if (k == 300) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for done/error", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ROM responder: data appears the cycle after rom_req
  initial forever begin
    @(posedge clk);
    #1;
    if (rom_req) begin
      rom_addr = rom_a[rom_idx];
      rom_data = rom_d[rom_idx];
      rom_mask = rom_m[rom_idx];
    end
  end

  // reg slave: ready in the third cycle of each request, echoes last write
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reg_valid || hold_ready) begin
        reg_ready = 1'b0;
        reg_error = 1'b0;
        cnt = 0;
      end else if (cnt == LAT) begin
        reg_ready = 1'b1;
        cnt = 0;
        reg_error = werr_en && reg_write && (reg_addr == werr_addr);
        reg_rdata = (force_en && reg_addr == force_addr) ? force_val : last_wdata;
        if (reg_write && !reg_error) last_wdata = reg_wdata;
      end else begin
        reg_ready = 1'b0;
        reg_error = 1'b0;
        cnt++;
      end
    end
  end

  // monitor: every completed reg transfer is popped against the scoreboard
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (rst_n && reg_valid && reg_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_txn actual wr=%0d addr=0x%0h data=0x%0h required none",
                 reg_write, reg_addr, reg_wdata);
      end else begin
        t = exp_q.pop_front();
        if (reg_write !== t.wr || reg_addr !== t.addr || (t.wr && reg_wdata !== t.data)) begin
          failures++;
          $display("FAIL txn actual wr=%0d addr=0x%0h data=0x%0h required wr=%0d addr=0x%0h data=0x%0h",
                   reg_write, reg_addr, reg_wdata, t.wr, t.addr, t.data);
        end
      end
    end
  end

  initial begin
    bit seen;
    load_default();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(reg_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", {30'd0, done, error}, 32'd0);
    check("rst_wstrb", 32'(reg_wstrb), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // three verified records, latency check
    for (int i = 0; i < 3; i++) begin
      exp_wr(32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
      exp_rd(32'h100 + 32'(4 * i));
    end
    start_run(3);
    check("lat_rom_req", 32'(rom_req), 32'd1);
    check("lat_rom_idx", 32'(rom_idx), 32'd0);
    @(negedge clk);
    check("lat_valid_t2", 32'(reg_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_t3", 32'(reg_valid), 32'd1);
    wait_end("t1");
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_writes", 32'(writes), 32'd3);

    // persistent mismatch on record 1 exhausts retries
    rom_d[1] = 32'h8000_0001;
    force_en = 1'b1; force_addr = 32'h104; force_val = 32'h0;
    exp_wr(32'h100, 32'h1000_0000); exp_rd(32'h100);
    for (int r = 0; r < 3; r++) begin
      exp_wr(32'h104, 32'h8000_0001); exp_rd(32'h104);
    end
    start_run(3);
    wait_end("t2");
    check("t2_error", 32'(error), 32'd1);
    check("t2_code", 32'(err_code), 32'd3);
    check("t2_idx", 32'(err_idx), 32'd1);
    check("t2_writes", 32'(writes), 32'd4);

    // masked compare only looks at bit 0
    rom_m[1] = 32'h0000_0001;
    force_val = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      exp_wr(32'h100 + 32'(4 * i), rom_d[i]);
      exp_rd(32'h100 + 32'(4 * i));
    end
    start_run(3);
    wait_end("t3");
    check("t3_done", 32'(done), 32'd1);
    check("t3_error", 32'(error), 32'd0);
    check("t3_writes", 32'(writes), 32'd3);
    force_en = 1'b0;
    load_default();

    // bus error on write of record 2
    werr_en = 1'b1; werr_addr = 32'h108;
    exp_wr(32'h100, 32'h1000_0000); exp_rd(32'h100);
    exp_wr(32'h104, 32'h1000_0001); exp_rd(32'h104);
    exp_wr(32'h108, 32'h1000_0002);
    start_run(4);
    wait_end("t4");
    check("t4_error", 32'(error), 32'd1);
    check("t4_code", 32'(err_code), 32'd1);
    check("t4_idx", 32'(err_idx), 32'd2);
    check("t4_writes", 32'(writes), 32'd2);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (reg_valid) seen = 1'b1;
    end
    check("t4_valid_after_err", 32'(seen), 32'd0);
    werr_en = 1'b0;

    // terminator at record 1; start pulse while busy is ignored
    rom_a[1] = 32'hFFFF_FFFF;
    exp_wr(32'h100, 32'h1000_0000); exp_rd(32'h100);
    start_run(5);
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    start = 1'b1; num_records = 5'd2;
    @(negedge clk);
    start = 1'b0;
    wait_end("t5");
    check("t5_done", 32'(done), 32'd1);
    check("t5_writes", 32'(writes), 32'd1);
    load_default();

    // zero records: done one cycle after start, no activity
    start_run(0);
    check("t0_rom_req", 32'(rom_req), 32'd0);
    @(negedge clk);
    check("t0_done", 32'(done), 32'd1);
    check("t0_writes", 32'(writes), 32'd0);

    // async reset in the middle of a stalled write
    hold_ready = 1'b1;
    start_run(3);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (reg_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("t6_valid_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(reg_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_write", 32'(reg_write), 32'd0);
    check("t6_rst_addr", reg_addr, 32'd0);
    check("t6_rst_writes", 32'(writes), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_wr(32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
      exp_rd(32'h100 + 32'(4 * i));
    end
    start_run(3);
    wait_end("t6");
    check("t6_done", 32'(done), 32'd1);
    check("t6_writes", 32'(writes), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
